// File: rtl/logic_gate_pkg.sv
// logic_gate_pkg: shared op codes and the per-bit gate function for logic_gate_pipe
package logic_gate_pkg;
  typedef logic [2:0] op_t;
  localparam op_t OP_AND  = 3'b000;
  localparam op_t OP_OR   = 3'b001;
  localparam op_t OP_XOR  = 3'b010;
  localparam op_t OP_NAND = 3'b011;
  localparam op_t OP_NOR  = 3'b100;
  localparam op_t OP_XNOR = 3'b101;
  typedef struct packed {
    logic err;
    logic z;
  } op_res_t;
  // One result bit; illegal codes force the bit to 0 and raise err.
  function automatic op_res_t apply_op(op_t op, logic a, logic b);
    op_res_t r;
    r.err = op > OP_XNOR;
    r.z   = op == OP_AND  ? a & b :
            op == OP_OR   ? a | b :
            op == OP_XOR  ? a ^ b :
            op == OP_NAND ? ~(a & b) :
            op == OP_NOR  ? ~(a | b) :
            op == OP_XNOR ? ~(a ^ b) : 1'b0;
    return r;
  endfunction
endpackage

// File: rtl/logic_gate_pipe_stage.sv
// pipe_stage: generic valid/ready register slice with full-throughput backpressure
module pipe_stage #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [DW-1:0] i_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_data
);
  logic          r_valid;
  logic [DW-1:0] r_data;
  assign o_ready = !r_valid || i_ready;
  assign o_valid = r_valid;
  assign o_data  = r_data;
  // load a new beat whenever the slot is empty or its beat is leaving
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (o_ready) begin
      r_valid <= i_valid;
      if (i_valid) r_data <= i_data;
    end
endmodule

// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe: 2-stage bitwise gate pipeline; LOGIC_GATE_PIPE_STATS_EN enables the result-change counter
module logic_gate_pipe
  import logic_gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] z,
  output logic             out_err,
  output logic [CNT_W-1:0] chg_cnt
);
  localparam int S1W = 3 + 2 * WIDTH;
  localparam int S2W = 1 + WIDTH;
  logic             w_s1_valid, w_s2_ready;
  logic [S1W-1:0]   w_s1_data;
  logic [S2W-1:0]   w_s2_data;
  op_t              w_op;
  logic [WIDTH-1:0] w_a, w_b, w_z, w_bit_err;
  assign {w_op, w_a, w_b} = w_s1_data;
  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    op_res_t w_r;
    assign w_r          = apply_op(w_op, w_a[g], w_b[g]);
    assign w_z[g]       = w_r.z;
    assign w_bit_err[g] = w_r.err;
  end
  pipe_stage #(.DW(S1W)) u_s1 (
    .clk(clk), .rst_n(rst_n),
    .i_valid(in_valid), .o_ready(in_ready), .i_data({op, x, y}),
    .o_valid(w_s1_valid), .i_ready(w_s2_ready), .o_data(w_s1_data)
  );
  pipe_stage #(.DW(S2W)) u_s2 (
    .clk(clk), .rst_n(rst_n),
    .i_valid(w_s1_valid), .o_ready(w_s2_ready), .i_data({|w_bit_err, w_z}),
    .o_valid(out_valid), .i_ready(out_ready), .o_data(w_s2_data)
  );
  assign {out_err, z} = w_s2_data;
`ifdef LOGIC_GATE_PIPE_STATS_EN
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_prev;
  // count output transfers whose result differs from the previous transfer, saturating
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_cnt  <= '0;
      r_prev <= '0;
    end else if (out_valid && out_ready) begin
      r_prev <= z;
      if (z != r_prev && r_cnt != '1) r_cnt <= r_cnt + 1'b1;
    end
  assign chg_cnt = r_cnt;
`else
  assign chg_cnt = '0;
`endif
endmodule
